// File: rtl/mult_bus_pkg.sv
// Shared types and defaults for the GPIO multiplier-emulator bus driver.
// Holds the FSM/phase encodings, the default register map and status bit positions.
package mult_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WR_A1   = 4'd1,
        ST_WR_A2   = 4'd2,
        ST_WR_GO   = 4'd3,
        ST_RD_STAT = 4'd4,
        ST_GAP     = 4'd5,
        ST_RD_W    = 4'd6,
        ST_RD_L    = 4'd7,
        ST_RESP    = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_STROBE = 2'd2,
        PH_HOLD   = 2'd3
    } phase_e;

    localparam logic [15:0] DEF_ADDR_A1   = 16'h037F;
    localparam logic [15:0] DEF_ADDR_A2   = 16'h0388;
    localparam logic [15:0] DEF_ADDR_W    = 16'h0390;
    localparam logic [15:0] DEF_ADDR_L    = 16'h0398;
    localparam logic [15:0] DEF_ADDR_CTRL = 16'h03A0;

    localparam int STAT_DONE  = 1;
    localparam int STAT_VALID = 0;

    function automatic logic [31:0] pad_operand(input logic [23:0] op);
        return {8'h00, op};
    endfunction

endpackage

// File: rtl/mult_bus_driver_seq.sv
// Single bus access sequencer: SETUP, STROBE_LEN strobe cycles, HOLD.
// A start seen during HOLD chains the next access with no idle cycle in between.
module bus_access_seq
    import mult_bus_pkg::*;
#(
    parameter int STROBE_LEN = 2
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic        rnw,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] sdata_in,
    output logic        done,
    output logic        idle,
    output logic [31:0] rdata,
    output logic [15:0] saddress,
    output logic [31:0] sdata_out,
    output logic        srd,
    output logic        swr
);

    localparam int SW = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
    localparam logic [SW-1:0] STROBE_LAST = SW'(STROBE_LEN - 1);

    phase_e          phase_r;
    logic            rnw_r;
    logic [SW-1:0]   strb_cnt_r;

    assign done  = (phase_r == PH_HOLD);
    assign idle  = (phase_r == PH_IDLE);
    assign rdata = sdata_in;

    // Access phase sequencing with registered, mutually exclusive strobes.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            phase_r    <= PH_IDLE;
            rnw_r      <= 1'b1;
            strb_cnt_r <= {SW{1'b0}};
            saddress   <= 16'h0000;
            sdata_out  <= 32'h0000_0000;
            srd        <= 1'b0;
            swr        <= 1'b0;
        end else begin
            case (phase_r)
                PH_IDLE, PH_HOLD: begin
                    if (start) begin
                        saddress  <= addr;
                        sdata_out <= wdata;
                        rnw_r     <= rnw;
                        phase_r   <= PH_SETUP;
                    end else begin
                        phase_r   <= PH_IDLE;
                    end
                end
                PH_SETUP: begin
                    srd        <= rnw_r;
                    swr        <= ~rnw_r;
                    strb_cnt_r <= {SW{1'b0}};
                    phase_r    <= PH_STROBE;
                end
                PH_STROBE: begin
                    if (strb_cnt_r == STROBE_LAST) begin
                        srd     <= 1'b0;
                        swr     <= 1'b0;
                        phase_r <= PH_HOLD;
                    end else begin
                        strb_cnt_r <= strb_cnt_r + SW'(1);
                    end
                end
                default: begin
                    srd     <= 1'b0;
                    swr     <= 1'b0;
                    phase_r <= PH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mult_bus_driver.sv
// Bus master that writes operands to the multiplier emulator, triggers it,
// polls for completion and returns product and ones count on a response port.
module mult_bus_driver
    import mult_bus_pkg::*;
#(
    parameter logic [15:0] ADDR_A1    = DEF_ADDR_A1,
    parameter logic [15:0] ADDR_A2    = DEF_ADDR_A2,
    parameter logic [15:0] ADDR_W     = DEF_ADDR_W,
    parameter logic [15:0] ADDR_L     = DEF_ADDR_L,
    parameter logic [15:0] ADDR_CTRL  = DEF_ADDR_CTRL,
    parameter int          STROBE_LEN = 2,
    parameter int          POLL_GAP   = 4,
    parameter int          POLL_MAX   = 255
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_a1,
    input  logic [23:0] cmd_a2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_w,
    output logic [23:0] rsp_ones,
    output logic [1:0]  rsp_status,
    output logic        rsp_timeout,
    output logic [15:0] saddress,
    output logic        swr,
    output logic        srd,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int GW = $clog2(POLL_GAP + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);

    state_e        state_r;
    logic [23:0]   a1_r;
    logic [23:0]   a2_r;
    logic [PW-1:0] poll_cnt_r;
    logic [GW-1:0] gap_cnt_r;

    logic          start_s;
    logic          rnw_s;
    logic [15:0]   addr_s;
    logic [31:0]   wdata_s;
    logic          done_s;
    logic          idle_s;
    logic [31:0]   rdata_s;
    logic          stat_done_s;

    assign stat_done_s = rdata_s[STAT_DONE];

    // Look ahead to the next access so it launches on the edge that ends HOLD.
    always_comb begin
        start_s = 1'b0;
        rnw_s   = 1'b1;
        addr_s  = ADDR_CTRL;
        wdata_s = 32'h0000_0000;
        case (state_r)
            ST_WR_A1: begin
                if (idle_s) begin
                    start_s = 1'b1;
                    rnw_s   = 1'b0;
                    addr_s  = ADDR_A1;
                    wdata_s = pad_operand(a1_r);
                end else if (done_s) begin
                    start_s = 1'b1;
                    rnw_s   = 1'b0;
                    addr_s  = ADDR_A2;
                    wdata_s = pad_operand(a2_r);
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_WR_A2: begin
                if (done_s) begin
                    start_s = 1'b1;
                    rnw_s   = 1'b0;
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_WR_GO: begin
                if (done_s) begin
                    start_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_RD_STAT: begin
                if (done_s && stat_done_s) begin
                    start_s = 1'b1;
                    addr_s  = ADDR_W;
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    start_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_RD_W: begin
                if (done_s) begin
                    start_s = 1'b1;
                    addr_s  = ADDR_L;
                end else begin
                    start_s = 1'b0;
                end
            end
            default: start_s = 1'b0;
        endcase
    end

    // Command/response FSM; every response field is a register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r     <= ST_IDLE;
            a1_r        <= 24'h000000;
            a2_r        <= 24'h000000;
            poll_cnt_r  <= {PW{1'b0}};
            gap_cnt_r   <= {GW{1'b0}};
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_w       <= 32'h0000_0000;
            rsp_ones    <= 24'h000000;
            rsp_status  <= 2'b00;
            rsp_timeout <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        a1_r        <= cmd_a1;
                        a2_r        <= cmd_a2;
                        cmd_ready   <= 1'b0;
                        rsp_w       <= 32'h0000_0000;
                        rsp_ones    <= 24'h000000;
                        rsp_status  <= 2'b00;
                        rsp_timeout <= 1'b0;
                        state_r     <= ST_WR_A1;
                    end
                end
                ST_WR_A1: if (done_s) state_r <= ST_WR_A2;
                ST_WR_A2: if (done_s) state_r <= ST_WR_GO;
                ST_WR_GO: if (done_s) state_r <= ST_RD_STAT;
                ST_RD_STAT: begin
                    if (done_s) begin
                        rsp_status <= rdata_s[1:0];
                        if (stat_done_s) begin
                            state_r <= ST_RD_W;
                        end else if (poll_cnt_r < POLL_LAST) begin
                            poll_cnt_r <= poll_cnt_r + PW'(1);
                            gap_cnt_r  <= {GW{1'b0}};
                            state_r    <= ST_GAP;
                        end else begin
                            rsp_timeout <= 1'b1;
                            rsp_w       <= 32'h0000_0000;
                            rsp_ones    <= 24'h000000;
                            rsp_valid   <= 1'b1;
                            state_r     <= ST_RESP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r <= ST_RD_STAT;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GW'(1);
                    end
                end
                ST_RD_W: begin
                    if (done_s) begin
                        rsp_w   <= rdata_s;
                        state_r <= ST_RD_L;
                    end
                end
                ST_RD_L: begin
                    if (done_s) begin
                        rsp_ones  <= rdata_s[23:0];
                        rsp_valid <= 1'b1;
                        state_r   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        poll_cnt_r <= {PW{1'b0}};
                        cmd_ready  <= 1'b1;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    bus_access_seq #(
        .STROBE_LEN (STROBE_LEN)
    ) u_seq (
        .clk       (clk),
        .n_reset   (n_reset),
        .start     (start_s),
        .rnw       (rnw_s),
        .addr      (addr_s),
        .wdata     (wdata_s),
        .sdata_in  (sdata_in),
        .done      (done_s),
        .idle      (idle_s),
        .rdata     (rdata_s),
        .saddress  (saddress),
        .sdata_out (sdata_out),
        .srd       (srd),
        .swr       (swr)
    );

endmodule

// File: tb/tb_mult_bus_driver.sv
// Directed/table-driven bench for mult_bus_driver with an inline emulator stub
// and a second instance configured for a short poll limit.
module tb_mult_bus_driver;
    import mult_bus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_reset;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_timeout;
    logic [23:0] cmd_a1, cmd_a2, rsp_ones;
    logic [31:0] rsp_w, sdata_out, sdata_in;
    logic [1:0]  rsp_status;
    logic [15:0] saddress;
    logic        swr, srd;

    logic        t_cmd_valid, t_cmd_ready, t_rsp_valid, t_rsp_ready, t_rsp_timeout;
    logic [23:0] t_cmd_a1, t_cmd_a2, t_rsp_ones;
    logic [31:0] t_rsp_w, t_sdata_out, t_sdata_in;
    logic [1:0]  t_rsp_status;
    logic [15:0] t_saddress;
    logic        t_swr, t_srd;

    mult_bus_driver dut (
        .clk(clk), .n_reset(n_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a1(cmd_a1), .cmd_a2(cmd_a2), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_w(rsp_w), .rsp_ones(rsp_ones), .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
        .saddress(saddress), .swr(swr), .srd(srd), .sdata_out(sdata_out), .sdata_in(sdata_in)
    );

    mult_bus_driver #(.POLL_MAX(3)) dut_to (
        .clk(clk), .n_reset(n_reset), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
        .cmd_a1(t_cmd_a1), .cmd_a2(t_cmd_a2), .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready),
        .rsp_w(t_rsp_w), .rsp_ones(t_rsp_ones), .rsp_status(t_rsp_status), .rsp_timeout(t_rsp_timeout),
        .saddress(t_saddress), .swr(t_swr), .srd(t_srd), .sdata_out(t_sdata_out), .sdata_in(t_sdata_in)
    );

    function automatic logic [47:0] prod48(input logic [23:0] a, input logic [23:0] b);
        return {24'h000000, a} * {24'h000000, b};
    endfunction

    function automatic logic [23:0] ones48(input logic [47:0] p);
        logic [23:0] n = 24'd0;
        for (int i = 0; i < 48; i++) n = n + {23'd0, p[i]};
        return n;
    endfunction

    typedef struct {
        logic        rnw;
        logic [15:0] addr;
        logic [31:0] data;
    } bus_rec_t;

    // Emulator stub state, written only by the bus monitor below
    bus_rec_t    log_q[$];
    logic [23:0] st_a1 = 24'd0, st_a2 = 24'd0, st_l = 24'd0;
    logic [31:0] st_w = 32'd0;
    logic [47:0] st_p;
    int          st_reads = 0, overlap = 0;
    logic        srd_q = 1'b0, swr_q = 1'b0;
    int          busy_polls = 0;

    int          t_stat_reads = 0, t_other_reads = 0, t_overlap = 0;
    logic        t_srd_q = 1'b0;

    assign sdata_in = (saddress == DEF_ADDR_CTRL) ? ((st_reads > busy_polls) ? 32'h3 : 32'h1) :
                      (saddress == DEF_ADDR_W)    ? st_w :
                      (saddress == DEF_ADDR_L)    ? {8'hC3, st_l} : 32'hDEAD_BEEF;
    assign t_sdata_in = (t_saddress == DEF_ADDR_CTRL) ? 32'h1 : 32'hA5A5_A5A5;

    always @(negedge clk) begin
        if (srd && swr) overlap++;
        if (t_srd && t_swr) t_overlap++;
        if (srd && !srd_q) begin
            log_q.push_back('{1'b1, saddress, 32'h0});
            if (saddress == DEF_ADDR_CTRL) st_reads++;
        end
        if (swr && !swr_q) begin
            log_q.push_back('{1'b0, saddress, sdata_out});
            case (saddress)
                DEF_ADDR_A1: st_a1 = sdata_out[23:0];
                DEF_ADDR_A2: st_a2 = sdata_out[23:0];
                DEF_ADDR_CTRL: begin
                    st_reads = 0;
                    st_p = prod48(st_a1, st_a2);
                    st_w = st_p[31:0];
                    st_l = ones48(st_p);
                end
                default: ;
            endcase
        end
        if (t_srd && !t_srd_q) begin
            if (t_saddress == DEF_ADDR_CTRL) t_stat_reads++;
            else t_other_reads++;
        end
        srd_q = srd;
        swr_q = swr;
        t_srd_q = t_srd;
    end

    typedef struct {
        logic [23:0] a1;
        logic [23:0] a2;
        int          polls;
        logic [31:0] w;
        logic [23:0] ones;
        int          lat;
    } vec_t;

    vec_t vecs[6];
    int   n_vec = 0, n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [23:0] a1, input logic [23:0] a2, output int lat);
        int guard = 0;
        @(negedge clk);
        cmd_a1 = a1;
        cmd_a2 = a2;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 2000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        check("cmd_ready_back", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat, base, n, guard, exp_n;
        logic        e_rnw;
        logic [15:0] e_addr;
        logic [31:0] e_data, r32;
        logic [23:0] ra1, ra2;
        logic [47:0] p;

        vecs[0] = '{24'h000003, 24'h000005, 0, 32'h0000_000F, 24'd4,  25};
        vecs[1] = '{24'h000007, 24'h000009, 3, 32'h0000_003F, 24'd6,  49};
        vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 0, 32'hFE00_0001, 24'd24, 25};
        vecs[3] = '{24'h000000, 24'h123456, 1, 32'h0000_0000, 24'd0,  33};
        vecs[4] = '{24'h000100, 24'h000100, 2, 32'h0001_0000, 24'd1,  41};
        vecs[5] = '{24'h800000, 24'h000002, 0, 32'h0100_0000, 24'd1,  25};

        n_reset = 1'b0;
        cmd_valid = 1'b0; cmd_a1 = 24'd0; cmd_a2 = 24'd0; rsp_ready = 1'b0;
        t_cmd_valid = 1'b0; t_cmd_a1 = 24'd0; t_cmd_a2 = 24'd0; t_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_bus", 64'({saddress, srd, swr}), 64'd0);
        check("rst_sdata_out", 64'(sdata_out), 64'd0);
        check("rst_rsp", 64'({rsp_w, rsp_ones, rsp_status, rsp_timeout}), 64'd0);
        n_reset = 1'b1;
        @(negedge clk);

        // Directed table: result, latency and exact bus transaction log
        for (int i = 0; i < 6; i++) begin
            busy_polls = vecs[i].polls;
            base = log_q.size();
            issue(vecs[i].a1, vecs[i].a2, lat);
            check("latency", 64'(lat), 64'(vecs[i].lat));
            check("rsp_w", 64'(rsp_w), 64'(vecs[i].w));
            check("rsp_ones", 64'(rsp_ones), 64'(vecs[i].ones));
            check("rsp_status", 64'(rsp_status), 64'd3);
            check("rsp_timeout", 64'(rsp_timeout), 64'd0);
            n = log_q.size() - base;
            exp_n = vecs[i].polls + 6;
            check("log_len", 64'(n), 64'(exp_n));
            for (int k = 0; k < n && k < exp_n; k++) begin
                e_rnw = 1'b1; e_data = 32'h0;
                if (k == 0) begin
                    e_rnw = 1'b0; e_addr = DEF_ADDR_A1; e_data = {8'h00, vecs[i].a1};
                end else if (k == 1) begin
                    e_rnw = 1'b0; e_addr = DEF_ADDR_A2; e_data = {8'h00, vecs[i].a2};
                end else if (k == 2) begin
                    e_rnw = 1'b0; e_addr = DEF_ADDR_CTRL;
                end else if (k == exp_n - 2) begin
                    e_addr = DEF_ADDR_W;
                end else if (k == exp_n - 1) begin
                    e_addr = DEF_ADDR_L;
                end else begin
                    e_addr = DEF_ADDR_CTRL;
                end
                check("bus_log", 64'({log_q[base+k].rnw, log_q[base+k].addr, log_q[base+k].data}),
                      64'({e_rnw, e_addr, e_data}));
            end
            finish_rsp();
        end

        // Timeout instance: status never done within three reads
        @(negedge clk);
        t_cmd_a1 = 24'd3; t_cmd_a2 = 24'd5; t_cmd_valid = 1'b1;
        guard = 0;
        while (!t_cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        t_cmd_valid = 1'b0;
        guard = 0;
        while (!t_rsp_valid && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("to_rsp_valid", 64'(t_rsp_valid), 64'd1);
        check("to_timeout", 64'(t_rsp_timeout), 64'd1);
        check("to_rsp_w", 64'(t_rsp_w), 64'd0);
        check("to_rsp_ones", 64'(t_rsp_ones), 64'd0);
        check("to_status", 64'(t_rsp_status), 64'd1);
        check("to_stat_reads", 64'(t_stat_reads), 64'd3);
        check("to_other_reads", 64'(t_other_reads), 64'd0);
        t_rsp_ready = 1'b1;
        @(negedge clk);
        t_rsp_ready = 1'b0;
        check("to_cmd_ready", 64'(t_cmd_ready), 64'd1);

        // Response back-pressure while commands are offered
        busy_polls = 0;
        issue(24'h00000A, 24'h00000B, lat);
        base = log_q.size();
        for (int c = 0; c < 10; c++) begin
            cmd_valid = c[0];
            cmd_a1 = 24'h00F000 + 24'(c);
            @(negedge clk);
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        cmd_valid = 1'b0;
        check("bp_rsp_w", 64'(rsp_w), 64'h6E);
        check("bp_rsp_ones", 64'(rsp_ones), 64'd5);
        check("bp_no_bus", 64'(log_q.size() - base), 64'd0);
        finish_rsp();

        // Reset while the A2 write strobe is high
        @(negedge clk);
        cmd_a1 = 24'h000111; cmd_a2 = 24'h000222; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        guard = 0;
        while (!(swr && saddress == DEF_ADDR_A2) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("rst_found_a2_strobe", 64'(swr && saddress == DEF_ADDR_A2), 64'd1);
        n_reset = 1'b0;
        #1;
        check("midrst_strobes", 64'({srd, swr}), 64'd0);
        check("midrst_bus", 64'({saddress, sdata_out}), 64'd0);
        check("midrst_ready", 64'({cmd_ready, rsp_valid}), 64'h2);
        check("midrst_rsp", 64'({rsp_w, rsp_ones}), 64'd0);
        @(negedge clk);
        n_reset = 1'b1;
        issue(24'h000123, 24'h000010, lat);
        check("post_rst_lat", 64'(lat), 64'd25);
        check("post_rst_w", 64'(rsp_w), 64'h1230);
        check("post_rst_ones", 64'(rsp_ones), 64'd4);
        finish_rsp();

        // Back-to-back random commands against the emulator model
        for (int r = 0; r < 100; r++) begin
            r32 = $urandom();
            ra1 = r32[23:0];
            r32 = $urandom();
            ra2 = r32[23:0];
            busy_polls = $urandom_range(0, 2);
            p = prod48(ra1, ra2);
            issue(ra1, ra2, lat);
            check("rnd_lat", 64'(lat), 64'(25 + 8 * busy_polls));
            check("rnd_w", 64'(rsp_w), 64'(p[31:0]));
            check("rnd_ones", 64'(rsp_ones), 64'(ones48(p)));
            check("rnd_timeout", 64'(rsp_timeout), 64'd0);
            finish_rsp();
        end

        check("srd_swr_exclusive", 64'(overlap), 64'd0);
        check("to_srd_swr_exclusive", 64'(t_overlap), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_bus_driver.md
Name: mult_bus_driver

Overview:
- Bus-master sequencer that drives the register interface of the GPIO multiplier emulator.
- Takes one operand pair per valid/ready command and writes A1 and A2 to the target.
- Triggers the operation, polls the target's status register until done, then reads back the product (W) and the ones count (L).
- Returns the result on a valid/ready response port. It sits between the test/host logic and the emulator's saddress/srd/swr/sdata bus.

Parameters:
ADDR_A1, 16'h037F, address of first operand register
ADDR_A2, 16'h0388, address of second operand register
ADDR_W, 16'h0390, address of product (low 32 bits) register
ADDR_L, 16'h0398, address of ones-count register
ADDR_CTRL, 16'h03A0, address of trigger (write) / status (read) register
STROBE_LEN, 2, cycles srd/swr are held high per access (>=1)
POLL_GAP, 4, idle cycles between consecutive status reads
POLL_MAX, 255, status reads allowed before timeout (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
n_reset  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  driver idle, command accepted when valid&ready
cmd_a1  in  24  first operand
cmd_a2  in  24  second operand
rsp_valid  out  1  response present, held until rsp_ready
rsp_ready  in  1  consumer accepts response
rsp_w  out  32  product read from ADDR_W
rsp_ones  out  24  ones count read from ADDR_L (bits 23:0)
rsp_status  out  2  last status value read from ADDR_CTRL (bits 1:0)
rsp_timeout  out  1  done bit never seen within POLL_MAX reads
saddress  out  16  bus address to target
swr  out  1  write strobe to target
srd  out  1  read strobe to target
sdata_out  out  32  write data to target sdata_in
sdata_in  in  32  read data from target sdata_out

Behaviour:
- Reset (async, immediate): cmd_ready=1, rsp_valid=0, rsp_w=0, rsp_ones=0, rsp_status=0, rsp_timeout=0, saddress=0, sdata_out=0, srd=0, swr=0, state=IDLE, poll count=0. Reset mid-access drops strobes at once; a partial transaction is abandoned and no response is produced.
- Every bus access has three phases:
  - SETUP: 1 cycle. saddress and sdata_out driven, strobes low.
  - STROBE: STROBE_LEN cycles. swr or srd high.
  - HOLD: 1 cycle. Strobes low, address and data unchanged.
- Each access is STROBE_LEN+2 cycles; saddress and sdata_out are stable across all three phases.
- Read data is captured from sdata_in on the clock edge that ends HOLD.
- srd and swr are never high together. Both are registered outputs and glitch-free.
- Main FSM: IDLE -> WR_A1 -> WR_A2 -> WR_GO -> RD_STAT -> (GAP -> RD_STAT)* -> RD_W -> RD_L -> RESP -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch the operands, set cmd_ready=0 and go to WR_A1.
- WR_A1 / WR_A2: write {8'h0, operand} to ADDR_A1 / ADDR_A2.
- WR_GO: write 32'h0 to ADDR_CTRL; the target treats this as the trigger.
- RD_STAT: read ADDR_CTRL and store bits 1:0 in rsp_status.
  - Bit1=1: go to RD_W.
  - Bit1=0 and poll count < POLL_MAX: wait POLL_GAP cycles (GAP), increment poll count, read again.
  - Bit1=0 and poll count = POLL_MAX: set rsp_timeout=1, rsp_w=0, rsp_ones=0, go to RESP.
- RD_W: read ADDR_W into rsp_w.
- RD_L: read ADDR_L; sdata_in[23:0] goes to rsp_ones.
- RESP: rsp_valid=1 with all rsp_* stable. On rsp_valid&rsp_ready, clear rsp_valid, clear poll count, return to IDLE. cmd_ready rises on the cycle after the handshake.
- Latency with defaults and done on the first poll: 6 accesses x 4 cycles. rsp_valid is first high 25 cycles after the accept edge.
- cmd_valid while busy is ignored (cmd_ready=0); no queueing.
- rsp_timeout and rsp_status persist until the next command is accepted.
- The poll counter width is clog2(POLL_MAX+1) and must not wrap.

Decomposition:
- Shared package mult_bus_pkg:
  - FSM state enum.
  - Default register addresses as localparams.
  - Status bit indices: STAT_DONE=1, STAT_VALID=0.
- One natural sub-module, bus_access_seq:
  - Inputs: start, rnw, addr, wdata.
  - Outputs: done, rdata; drives saddress/sdata_out/srd/swr.
  - Implements the SETUP/STROBE/HOLD timing.
- Top-level FSM issues one access at a time to bus_access_seq.

Test Plan:
1. Target stub returns status 11 on first poll, W=32'h0000000F, L=4; cmd a1=3, a2=5. Bus log must be:
   - writes 37F=3, 388=5, 3A0=0;
   - reads 3A0, 390, 398.
   Response: rsp_w=0x0000000F, rsp_ones=4, rsp_status=2'b11, rsp_timeout=0, rsp_valid at cycle 25.
2. Stub status 01 for 3 polls then 11. Expect exactly 4 status reads, POLL_GAP=4 idle cycles between reads, correct W/L returned.
3. POLL_MAX=3, stub status always 01. Expect 3 status reads, no reads of 390/398, rsp_timeout=1, rsp_w=0, rsp_ones=0, rsp_status=01.
4. Hold rsp_ready=0 for 10 cycles while pulsing cmd_valid. Expect rsp_* stable, cmd_ready=0, no bus activity until the handshake.
5. Assert n_reset low during the STROBE of the WR_A2 write. Expect swr=0 immediately, all outputs at reset values, a clean restart on the next command.
6. Run 100 back-to-back random commands (a1, a2 random 24-bit) against a behavioural emulator model. Expect responses in order, every rsp_w and rsp_ones matching the model, and srd&swr never high together.
